// File: rtl/pcs_codes_pkg.sv
// Code-group constants and transmit sequencer state encoding shared by the
// 1000BASE-X transmit PCS blocks.
package pcs_codes_pkg;

   localparam logic [7:0] K28_5   = 8'hBC;
   localparam logic [7:0] D16_2   = 8'h50;
   localparam logic [7:0] K27_7_S = 8'hFB;
   localparam logic [7:0] K29_7_T = 8'hFD;
   localparam logic [7:0] K23_7_R = 8'hF7;
   localparam logic [7:0] K30_7_V = 8'hFE;

   // Each state names the code-group emitted on the next clock edge.
   typedef enum logic [2:0] {
      IDLE_K = 3'd0,
      IDLE_D = 3'd1,
      DATA   = 3'd2,
      EPD_R  = 3'd3,
      EPD_R2 = 3'd4
   } tx_state_e;

endpackage

// File: rtl/pcs_tx_oset_sequencer.sv
// 1000BASE-X transmit ordered-set sequencer: turns GMII TX_EN/TX_ER/TXD into
// a stream of /I2/, /S/, data, /V/, /T/ and /R/ code-groups for the encoder.
module pcs_tx_oset_sequencer
   import pcs_codes_pkg::*;
#(
   parameter int PKT_CNT_W = 16
) (
   input  logic                 GTX_CLK,
   input  logic                 RESET,
   input  logic                 TX_EN,
   input  logic                 TX_ER,
   input  logic [7:0]           TXD,
   output logic [7:0]           tx_code,
   output logic                 tx_is_k,
   output logic                 tx_even,
   output logic                 TX_OSET_indicate,
   output logic [PKT_CNT_W-1:0] pkt_count
);

   tx_state_e            state_q, state_d;
   logic                 en_q, er_q;
   logic [7:0]           txd_q;
   logic [7:0]           code_q, code_d;
   logic                 is_k_q, is_k_d;
   logic                 even_q;
   logic                 oset_q, oset_d;
   logic [PKT_CNT_W-1:0] cnt_q, cnt_d;
   logic                 slot_even;

   // even_q describes the code-group now on the output; the one being
   // computed occupies the opposite slot.
   assign slot_even = ~even_q;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d = state_q;
      code_d  = K28_5;
      is_k_d  = 1'b1;
      oset_d  = 1'b0;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE_K: begin
            if (en_q) begin
               code_d  = K27_7_S;
               oset_d  = 1'b1;
               state_d = DATA;
            end else begin
               state_d = IDLE_D;
            end
         end
         IDLE_D: begin
            code_d  = D16_2;
            is_k_d  = 1'b0;
            oset_d  = 1'b1;
            state_d = IDLE_K;
         end
         DATA: begin
            oset_d = 1'b1;
            if (!en_q) begin
               code_d  = K29_7_T;
               cnt_d   = cnt_q + PKT_CNT_W'(1);
               state_d = EPD_R;
            end else if (er_q) begin
               code_d = K30_7_V;
            end else begin
               code_d = txd_q;
               is_k_d = 1'b0;
            end
         end
         EPD_R: begin
            // An /R/ on an even slot needs a second /R/ so idle restarts even.
            code_d = K23_7_R;
            if (slot_even) begin
               state_d = EPD_R2;
            end else begin
               oset_d  = 1'b1;
               state_d = IDLE_K;
            end
         end
         EPD_R2: begin
            code_d  = K23_7_R;
            oset_d  = 1'b1;
            state_d = IDLE_K;
         end
         default: begin
            state_d = IDLE_K;
         end
      endcase
   end

   always_ff @(posedge GTX_CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RESET) begin
         en_q    <= 1'b0;
         er_q    <= 1'b0;
         txd_q   <= 8'h00;
         state_q <= IDLE_D;
         code_q  <= K28_5;
         is_k_q  <= 1'b1;
         even_q  <= 1'b1;
         oset_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         en_q    <= TX_EN;
         er_q    <= TX_ER;
         txd_q   <= TXD;
         state_q <= state_d;
         code_q  <= code_d;
         is_k_q  <= is_k_d;
         even_q  <= ~even_q;
         oset_q  <= oset_d;
         cnt_q   <= cnt_d;
      end
   end

   assign tx_code          = code_q;
   assign tx_is_k          = is_k_q;
   assign tx_even          = even_q;
   assign TX_OSET_indicate = oset_q;
   assign pkt_count        = cnt_q;

endmodule
